quantizer_multilane: RTL and testbench
======================================

QUANTIZER_MULTILANE -- requirements
Module: quantizer_multilane

Interface
REQ-001 Parameter LANES, default 4: number of parallel quantizer lanes per beat.
REQ-002 Parameter IN_W, default 32: signed accumulator input width per lane.
REQ-003 Parameter OUT_W, default 8: signed quantized output width per lane (legal range 2..16).
REQ-004 Parameter FRAC, default 24: fractional bits of the scale (Q(32-FRAC).FRAC).
REQ-005 Parameter CNT_W, default 16: width of the saturation event counter.
REQ-006 Single clock domain; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  block can accept a beat this cycle.
REQ-011 in_data  in  LANES*IN_W  signed accumulators; lane i at bits [i*IN_W +: IN_W].
REQ-012 in_scale  in  LANES*32  per-lane signed reciprocal scale, sampled with in_data.
REQ-013 zero_point  in  OUT_W  signed output zero point, sampled with in_data.
REQ-014 relu_en  in  1  ReLU mode, sampled with in_data.
REQ-015 out_valid  out  1  output beat valid.
REQ-016 out_ready  in  1  downstream accepts the beat.
REQ-017 out_data  out  LANES*OUT_W  signed quantized values, same lane packing.
REQ-018 out_sat  out  LANES  per-lane flag: this lane's value was clamped.
REQ-019 sat_count  out  CNT_W  saturating count of beats with any lane clamped.
REQ-020 sat_clr  in  1  synchronous clear of sat_count.

Function
REQ-021 Four-stage pipeline: S1 register inputs, S2 multiply, S3 round/shift/add zero point, S4 ReLU/clamp/output register; latency exactly 4 cycles when unstalled.
REQ-022 Beat transfers in when in_valid && in_ready; out when out_valid && out_ready.
REQ-023 Global advance enable = out_ready || !out_valid; all stages and valids move only when enable is 1; otherwise every stage holds.
REQ-024 in_ready = enable (combinational); bubbles are not compacted; full throughput of 1 beat/cycle while out_ready is 1.
REQ-025 S2 product: signed IN_W x signed 32, full IN_W+32 bits, no truncation.
REQ-026 S3: r = (product + 2^(FRAC-1)) >>> FRAC (round half toward +inf), then v = r + sign-extended zero_point, computed at full width.
REQ-027 S4 ReLU: when relu_en for that beat and v < zero_point, v := zero_point.
REQ-028 S4 clamp: v > 2^(OUT_W-1)-1 -> max; v < -2^(OUT_W-1) -> min; else low OUT_W bits; out_sat[i] = 1 iff clamped (ReLU alone does not set it).
REQ-029 out_data and out_sat hold their values while out_valid && !out_ready.
REQ-030 sat_count increments by 1 on each output handshake where |out_sat; holds at 2^CNT_W-1.
REQ-031 sat_clr and an increment in the same cycle: clear wins, count = 0.
REQ-032 relu_en and zero_point travel with their beat; changes never affect beats already in flight.

Reset
REQ-033 While reset is high at a clock edge: all stage valids, out_valid = 0, out_data = 0, out_sat = 0, sat_count = 0; data stage registers need not be cleared.
REQ-034 Reset mid-operation discards all in-flight beats; first post-reset output appears 4 cycles after the first accepted beat.
REQ-035 in_ready = 1 during and after reset (out_valid is 0).

Structure
REQ-036 Package quant_pkg holds the FRAC default, the scale width (32) and a function returning clamp min/max for a given OUT_W.
REQ-037 One sub-module quant_lane (S2-S4 datapath for a single lane, enable-gated) instantiated LANES times via generate; valid/enable control and sat_count live in the top.

Verification
REQ-038 LANES=4, scale 0x0100_0000 (1.0), zp 0, data {100,-100,3,-3} -> out {100,-100,3,-3}, out_sat 0, out_valid 4 cycles after accept.
REQ-039 Scale 0x0080_0000 (0.5), data {3,-3,1000,-1000} -> {2,-1,127,-128}, out_sat 4'b1100, sat_count 1.
REQ-040 relu_en=1, zp=10, scale 1.0, data {-50,5,120,0} -> {10,15,127,10}, out_sat 4'b0100.
REQ-041 Stream 8 beats, out_ready low 3 cycles mid-stream -> in_ready low those cycles, held out_data stable, all 8 beats in order, none lost or duplicated.
REQ-042 Assert reset with 3 beats in flight -> out_valid 0 next cycle, sat_count 0, none of the 3 beats ever emitted; sat_clr coincident with a saturating handshake -> sat_count 0.

Source files
------------

// File: rtl/quant_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quant_pkg
//  Description : Shared constants and clamp-limit helper for the multilane
//                requantizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package quant_pkg;

    // Default number of fractional bits in the per-lane reciprocal scale
    localparam int c_frac_default = 24;

    // Width of each per-lane scale word
    localparam int c_scale_w = 32;

    // Signed saturation bounds for a given output width
    typedef struct packed {
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
    } clamp_t;

    // Returns the representable range of a signed out_w-bit value
    function automatic clamp_t clamp_limits(input int out_w);
        clamp_t r;
        r.max_v = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        r.min_v = -(32'sd1 <<< (out_w - 1));
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quant_lane.sv
`default_nettype none
// ============================================================================
//  Module      : quant_lane
//  Description : Multiply, round/shift/offset and ReLU/clamp datapath for one
//                lane. Every stage advances only when i_en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module quant_lane
    import quant_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int FRAC  = c_frac_default
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic signed [IN_W-1:0]  i_data,
    input  logic signed [31:0]      i_scale,
    input  logic signed [OUT_W-1:0] i_zp,
    input  logic                    i_relu,
    output logic signed [OUT_W-1:0] o_q,
    output logic                    o_sat
);

    // Full product width, plus two guard bits so rounding and the zero-point
    // add can never wrap
    localparam int c_pw = IN_W + c_scale_w;
    localparam int c_vw = c_pw + 2;

    localparam clamp_t             c_lim   = clamp_limits(OUT_W);
    localparam logic signed [31:0] c_max32 = c_lim.max_v;
    localparam logic signed [31:0] c_min32 = c_lim.min_v;
    localparam logic signed [c_vw-1:0] c_max  = c_vw'(c_max32);
    localparam logic signed [c_vw-1:0] c_min  = c_vw'(c_min32);
    localparam logic signed [c_vw-1:0] c_half = {{(c_vw-1){1'b0}}, 1'b1} << (FRAC - 1);

    // S2 state
    logic signed [c_pw-1:0]  r_s2_prod;
    logic signed [OUT_W-1:0] r_s2_zp;
    logic                    r_s2_relu;
    // S3 state
    logic signed [c_vw-1:0]  r_s3_v;
    logic signed [OUT_W-1:0] r_s3_zp;
    logic                    r_s3_relu;
    // S4 (output) state
    logic signed [OUT_W-1:0] r_q;
    logic                    r_sat;

    logic signed [c_pw-1:0]  w_a;
    logic signed [c_pw-1:0]  w_b;
    logic signed [c_pw-1:0]  w_prod;
    logic signed [c_vw-1:0]  w_rnd;
    logic signed [c_vw-1:0]  w_r;
    logic signed [c_vw-1:0]  w_s2_zp_ext;
    logic signed [c_vw-1:0]  w_v;
    logic signed [c_vw-1:0]  w_s3_zp_ext;
    logic signed [c_vw-1:0]  w_relu_v;
    logic signed [OUT_W-1:0] w_q;
    logic                    w_sat;

    // Sign-extend both operands to the product width; the low c_pw bits of
    // the product are then the exact signed result
    assign w_a    = {{c_scale_w{i_data[IN_W-1]}}, i_data};
    assign w_b    = {{IN_W{i_scale[31]}}, i_scale};
    assign w_prod = w_a * w_b;

    // Round half toward +inf, drop the fraction, then add the zero point
    assign w_rnd       = {{2{r_s2_prod[c_pw-1]}}, r_s2_prod} + c_half;
    assign w_r         = w_rnd >>> FRAC;
    assign w_s2_zp_ext = {{(c_vw-OUT_W){r_s2_zp[OUT_W-1]}}, r_s2_zp};
    assign w_v         = w_r + w_s2_zp_ext;

    assign w_s3_zp_ext = {{(c_vw-OUT_W){r_s3_zp[OUT_W-1]}}, r_s3_zp};

    // ReLU floors at the zero point; clamping alone raises the sat flag
    always_comb begin
        w_relu_v = r_s3_v;
        if (r_s3_relu && (r_s3_v < w_s3_zp_ext)) begin
            w_relu_v = w_s3_zp_ext;
        end
        w_q   = w_relu_v[OUT_W-1:0];
        w_sat = 1'b0;
        if (w_relu_v > c_max) begin
            w_q   = c_max[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_relu_v < c_min) begin
            w_q   = c_min[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    // S2/S3 data registers; contents are qualified by the valids in the top
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_s2_prod <= w_prod;
            r_s2_zp   <= i_zp;
            r_s2_relu <= i_relu;
            r_s3_v    <= w_v;
            r_s3_zp   <= r_s2_zp;
            r_s3_relu <= r_s2_relu;
        end
    end

    // Output register: cleared by reset, held while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_q   <= w_q;
            r_sat <= w_sat;
        end
    end

    assign o_q   = r_q;
    assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/quantizer_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : quantizer_multilane
//  Description : Four-stage, LANES-wide requantizer (multiply by reciprocal
//                scale, round, add zero point, optional ReLU, clamp) with a
//                single global stall and a saturating clamp-event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module quantizer_multilane
    import quant_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int FRAC  = c_frac_default,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    input  logic [LANES*32-1:0]      in_scale,
    input  logic [OUT_W-1:0]         zero_point,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    output logic [CNT_W-1:0]         sat_count,
    input  logic                     sat_clr
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic                       w_en;
    logic                       w_hs_sat;
    logic                       r_v1;
    logic                       r_v2;
    logic                       r_v3;
    logic                       r_v4;
    logic [LANES*IN_W-1:0]      r_s1_data;
    logic [LANES*32-1:0]        r_s1_scale;
    logic [OUT_W-1:0]           r_s1_zp;
    logic                       r_s1_relu;
    logic [CNT_W-1:0]           r_cnt;

    // The whole pipeline moves as one: it advances whenever the output
    // register is empty or being drained, so bubbles are never squeezed out
    assign w_en      = out_ready || !out_valid;
    assign in_ready  = w_en;
    assign out_valid = r_v4;

    // Stage valid shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    // S1 input capture; zero point and ReLU mode ride along with the beat
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_data  <= in_data;
            r_s1_scale <= in_scale;
            r_s1_zp    <= zero_point;
            r_s1_relu  <= relu_en;
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            quant_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W),
                .FRAC  (FRAC)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .i_en    (w_en),
                .i_data  (r_s1_data[i*IN_W +: IN_W]),
                .i_scale (r_s1_scale[i*32 +: 32]),
                .i_zp    (r_s1_zp),
                .i_relu  (r_s1_relu),
                .o_q     (out_data[i*OUT_W +: OUT_W]),
                .o_sat   (out_sat[i])
            );
        end
    endgenerate

    assign w_hs_sat = out_valid && out_ready && (|out_sat);

    // Saturating count of delivered beats that had any lane clamped; an
    // explicit clear overrides a coincident increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (sat_clr) begin
            r_cnt <= '0;
        end else if (w_hs_sat && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sat_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_quantizer_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quantizer_multilane
//  Description : Self-checking bench for quantizer_multilane with a
//                behavioural reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quantizer_multilane;

    localparam int LANES = 4;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int FRAC  = 24;
    localparam int CNT_W = 4;
    localparam int c_cnt_max = (1 << CNT_W) - 1;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*IN_W-1:0]    in_data;
    logic [LANES*32-1:0]      in_scale;
    logic [OUT_W-1:0]         zero_point;
    logic                     relu_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [LANES-1:0]         out_sat;
    logic [CNT_W-1:0]         sat_count;
    logic                     sat_clr;

    quantizer_multilane #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .FRAC  (FRAC),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_scale   (in_scale),
        .zero_point (zero_point),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_count  (sat_count),
        .sat_clr    (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*OUT_W-1:0] d;
        logic [LANES-1:0]       s;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    int   m_cnt  = 0;
    bit   prev_reset = 1'b0;
    bit   held_valid = 1'b0;
    logic [LANES*OUT_W-1:0] held_data;
    logic [LANES-1:0]       held_sat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on each lane
    function automatic exp_t model(input logic [LANES*IN_W-1:0] d, input logic [LANES*32-1:0] sc,
                                   input logic [OUT_W-1:0] zp, input logic relu);
        exp_t   e;
        longint a, b, p, v, z, hi, lo;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -(64'sd1 <<< (OUT_W - 1));
        z  = longint'($signed(zp));
        for (int i = 0; i < LANES; i++) begin
            a = longint'($signed(d[i*IN_W +: IN_W]));
            b = longint'($signed(sc[i*32 +: 32]));
            p = a * b;
            v = ((p + (64'sd1 <<< (FRAC - 1))) >>> FRAC) + z;
            if (relu && v < z) v = z;
            e.s[i] = 1'b0;
            if (v > hi) begin v = hi; e.s[i] = 1'b1; end
            else if (v < lo) begin v = lo; e.s[i] = 1'b1; end
            e.d[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        return e;
    endfunction

    function automatic logic [127:0] pk32(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] x0, x1, x2, x3;
        x0 = a0; x1 = a1; x2 = a2; x3 = a3;
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [31:0] pk8(input int a0, input int a1, input int a2, input int a3);
        logic [7:0] x0, x1, x2, x3;
        x0 = a0[7:0]; x1 = a1[7:0]; x2 = a2[7:0]; x3 = a3[7:0];
        return {x3, x2, x1, x0};
    endfunction

    // Per-cycle checker: protocol, ordering, hold-while-stalled, counter
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            m_cnt      = 0;
            prev_reset = 1'b1;
            held_valid = 1'b0;
        end else begin
            if (prev_reset) begin
                chk("post_reset_out_valid", {127'd0, out_valid}, 128'd0);
                chk("post_reset_out_data", {96'd0, out_data}, 128'd0);
                chk("post_reset_out_sat", {124'd0, out_sat}, 128'd0);
                chk("post_reset_sat_count", {124'd0, sat_count}, 128'd0);
            end
            chk("in_ready", {127'd0, in_ready}, {127'd0, (out_ready || !out_valid)});
            if (held_valid) begin
                chk("held_out_data", {96'd0, out_data}, {96'd0, held_data});
                chk("held_out_sat", {124'd0, out_sat}, {124'd0, held_sat});
            end
            chk("sat_count", {124'd0, sat_count}, 128'(m_cnt));
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, in_scale, zero_point, relu_en));
            e.s = '0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {96'd0, out_data}, 128'hDEAD);
                end else begin
                    e = exp_q[0];
                    chk("out_data", {96'd0, out_data}, {96'd0, e.d});
                    chk("out_sat", {124'd0, out_sat}, {124'd0, e.s});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (sat_clr) m_cnt = 0;
            else if (out_valid && out_ready && (|e.s) && m_cnt < c_cnt_max) m_cnt++;
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            held_sat   = out_sat;
            prev_reset = 1'b0;
        end
    end

    // Present one beat and hold it until accepted
    task automatic push(input logic [127:0] d, input logic [127:0] sc, input logic [7:0] zp,
                        input logic relu);
        bit acc;
        int budget;
        in_data = d; in_scale = sc; zero_point = zp; relu_en = relu; in_valid = 1'b1;
        acc = 1'b0; budget = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 128'd0, 128'd1);
    endtask

    // One isolated beat with literal expectations and a latency check
    task automatic send_check(input string name, input logic [127:0] d, input logic [127:0] sc,
                              input logic [7:0] zp, input logic relu, input logic [31:0] xd,
                              input logic [3:0] xs, input int xcnt);
        int lat;
        push(d, sc, zp, relu);
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'd4);
        chk({name, "_data"}, {96'd0, out_data}, {96'd0, xd});
        chk({name, "_sat"}, {124'd0, out_sat}, {124'd0, xs});
        @(posedge clk);
        #1;
        chk({name, "_count"}, {124'd0, sat_count}, 128'(xcnt));
    endtask

    localparam logic [127:0] c_one  = {4{32'h0100_0000}};
    localparam logic [127:0] c_half = {4{32'h0080_0000}};

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_scale = '0; zero_point = '0;
        relu_en = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", {127'd0, in_ready}, 128'd1);
        chk("out_valid_in_reset", {127'd0, out_valid}, 128'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Identity scale, mixed signs
        send_check("unity", pk32(100, -100, 3, -3), c_one, 8'd0, 1'b0,
                   pk8(100, -100, 3, -3), 4'b0000, 0);
        // Half scale: rounding half up and both clamp directions
        send_check("half", pk32(3, -3, 1000, -1000), c_half, 8'd0, 1'b0,
                   pk8(2, -1, 127, -128), 4'b1100, 1);
        // ReLU floors at zero point; only the clamp sets the flag
        send_check("relu", pk32(-50, 5, 120, 0), c_one, 8'd10, 1'b1,
                   pk8(10, 15, 127, 10), 4'b0100, 2);

        // Eight-beat stream with a three-cycle downstream stall
        base = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    push(pk32(k * 30, -k * 30, k, 7), c_one, 8'(k), k[0]);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("stream_count", 128'(n_out - base), 128'd8);
        chk("stream_drained", 128'(exp_q.size()), 128'd0);

        // Clear coincident with a saturating handshake
        push(pk32(1000, 0, 0, 0), c_one, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("clr_beat_valid", {127'd0, out_valid}, 128'd1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        chk("clr_wins", {124'd0, sat_count}, 128'd0);

        // Counter must stick at its maximum
        for (int k = 0; k < c_cnt_max + 2; k++)
            push(pk32(1000, -1000, 5, 5), c_one, 8'd0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("count_saturates", {124'd0, sat_count}, 128'(c_cnt_max));

        // Reset with three beats in flight
        base = n_out;
        for (int k = 0; k < 3; k++)
            push(pk32(500, 1, 2, 3), c_one, 8'd0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_sat_count", {124'd0, sat_count}, 128'd0);
        chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("reset_no_emit", 128'(n_out - base), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
